mole_spawner: RTL and testbench

Mole launch scheduler for the whack-a-mole game: the initiating side of the per-mole `control` go lines that the mole rise/lower and scoring logic consumes. It watches the packed mole heights and hit strobes, tracks which moles are busy, and at a fixed spawn period issues a one-cycle go pulse to one pseudo-randomly chosen idle mole. It also reports occupancy and the number of launches issued.

---
 rtl/mole_spawner.sv | 133 +++++++++++++
 tb/tb_mole_spawner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mole_spawner.sv
// Mole launch scheduler: at each spawn tick, fires a one-cycle go pulse at a pseudo-random idle mole
// and tracks each mole's LAUNCHED/UP occupancy until it is hit, sinks back, or times out.
module mole_spawner #(
    parameter int          SPAWN_PERIOD   = 25_000_000,
    parameter int          MAX_ACTIVE     = 3,
    parameter int          LAUNCH_TIMEOUT = 50_000_000,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        enable,
    input  logic [39:0] Mheight,
    input  logic [7:0]  mole_hit,
    output logic [7:0]  control,
    output logic [7:0]  active,
    output logic [3:0]  active_count,
    output logic [15:0] spawn_count
);

    localparam int          PW          = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int          TW          = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
    localparam logic [15:0] LFSR_INIT   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [PW-1:0] PERIOD_LAST  = PW'(SPAWN_PERIOD - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LAUNCH_TIMEOUT - 1);
    localparam logic [3:0]  MAX_CNT     = 4'(MAX_ACTIVE);

    typedef enum logic [1:0] {IDLE, LAUNCHED, UP} track_t;

    logic [15:0]   lfsr;
    logic [PW-1:0] period_cnt;
    track_t        state     [8];
    track_t        state_nxt [8];
    logic [TW-1:0] tcnt      [8];
    logic [TW-1:0] tcnt_nxt  [8];
    logic [4:0]    height    [8];
    logic [7:0]    eligible;
    logic [7:0]    launch_vec;
    logic [7:0]    active_nxt;
    logic [3:0]    count_nxt;
    logic [2:0]    sel;
    logic          found;
    logic          tick;
    logic          launch;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            height[i]   = Mheight[39-5*i -: 5];
            eligible[i] = (state[i] == IDLE) && !mole_hit[i] && (height[i] == 5'd0);
        end
    end

    // Rotating priority search starting at the LFSR's low three bits.
    always_comb begin
        logic [2:0] idx;
        found = 1'b0;
        sel   = 3'd0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = lfsr[2:0] + 3'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign tick       = enable && (period_cnt == PERIOD_LAST);
    assign launch     = tick && (active_count < MAX_CNT) && found;
    assign launch_vec = launch ? (8'b1 << sel) : 8'h00;

    // Tracker transitions; hit outranks timeout, which outranks the height check.
    always_comb begin
        count_nxt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            state_nxt[i] = state[i];
            tcnt_nxt[i]  = tcnt[i];
            case (state[i])
                IDLE: begin
                    if (launch_vec[i]) begin
                        state_nxt[i] = LAUNCHED;
                        tcnt_nxt[i]  = '0;
                    end
                end
                LAUNCHED: begin
                    if (mole_hit[i] || (tcnt[i] == TIMEOUT_LAST))
                        state_nxt[i] = IDLE;
                    else if (height[i] != 5'd0)
                        state_nxt[i] = UP;
                    else
                        tcnt_nxt[i] = tcnt[i] + 1'b1;
                end
                UP: begin
                    if (mole_hit[i] || (height[i] == 5'd0))
                        state_nxt[i] = IDLE;
                end
                default: state_nxt[i] = IDLE;
            endcase
            active_nxt[i] = (state_nxt[i] != IDLE);
            count_nxt     = count_nxt + 4'(active_nxt[i]);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            lfsr         <= LFSR_INIT;
            period_cnt   <= '0;
            control      <= 8'h00;
            active       <= 8'h00;
            active_count <= 4'd0;
            spawn_count  <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                state[i] <= IDLE;
                tcnt[i]  <= '0;
            end
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
            if (!enable || (period_cnt == PERIOD_LAST))
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 1'b1;
            for (int i = 0; i < 8; i++) begin
                state[i] <= state_nxt[i];
                tcnt[i]  <= tcnt_nxt[i];
            end
            control      <= launch_vec;
            active       <= active_nxt;
            active_count <= count_nxt;
            if (launch && (spawn_count != 16'hFFFF))
                spawn_count <= spawn_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner: one fast-timeout instance for spawn/tracker behaviour and
// one capped instance for the MAX_ACTIVE limit.
module tb_mole_spawner;

    logic        clock;
    logic        resetn;
    logic        enable_a, enable_b;
    logic [39:0] mheight_a, mheight_b;
    logic [7:0]  mole_hit_a, mole_hit_b;
    logic [7:0]  control_a, control_b, active_a, active_b;
    logic [3:0]  active_count_a, active_count_b;
    logic [15:0] spawn_count_a, spawn_count_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          release_at [8];
    logic [15:0] m_lfsr;
    logic [15:0] lfsr_prev;

    mole_spawner #(.SPAWN_PERIOD(4), .MAX_ACTIVE(8), .LAUNCH_TIMEOUT(10), .SEED(16'hACE1)) u_a (
        .CLOCK_50(clock), .resetn(resetn), .enable(enable_a), .Mheight(mheight_a),
        .mole_hit(mole_hit_a), .control(control_a), .active(active_a),
        .active_count(active_count_a), .spawn_count(spawn_count_a));

    mole_spawner #(.SPAWN_PERIOD(4), .MAX_ACTIVE(3), .LAUNCH_TIMEOUT(1000), .SEED(16'hACE1)) u_b (
        .CLOCK_50(clock), .resetn(resetn), .enable(enable_b), .Mheight(mheight_b),
        .mole_hit(mole_hit_b), .control(control_b), .active(active_b),
        .active_count(active_count_b), .spawn_count(spawn_count_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference Galois LFSR, mask 16'hB400, free-running out of reset.
    always @(posedge clock or negedge resetn) begin
        if (!resetn)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [39:0] heights, input logic [7:0] hits);
        enable_a   = en;
        mheight_a  = heights;
        mole_hit_a = hits;
    endtask

    task automatic stepCycle();
        lfsr_prev = m_lfsr;
        @(negedge clock);
        cyc++;
    endtask

    task automatic waitPulse(output int idx, output bit ok);
        ok  = 1'b0;
        idx = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            stepCycle();
            if (control_a != 8'h00) begin
                ok = 1'b1;
                for (int i = 0; i < 8; i++)
                    if (control_a[i]) idx = i;
            end
        end
        checkOutput("pulse_seen", 32'(ok), 32'd1);
    endtask

    logic [7:0]  busy, exp_ctrl, exp_active;
    logic [2:0]  start;
    logic [15:0] sc_hold;
    int          exp_sc, pick, pos, pulses, k, j;
    bit          found, ok;

    initial begin
        resetn = 1'b0;
        enable_b = 1'b0; mheight_b = '0; mole_hit_b = '0;
        applyStimulus(1'b0, 40'h0, 8'h00);
        for (int i = 0; i < 8; i++) release_at[i] = 0;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'($urandom()), 40'({$urandom(), $urandom()}), 8'($urandom()));
            enable_b   = 1'($urandom());
            mheight_b  = 40'({$urandom(), $urandom()});
            mole_hit_b = 8'($urandom());
            stepCycle();
        end
        checkOutput("rst_control_a", 32'(control_a), 32'h0);
        checkOutput("rst_active_a", 32'(active_a), 32'h0);
        checkOutput("rst_active_count_a", 32'(active_count_a), 32'h0);
        checkOutput("rst_spawn_count_a", 32'(spawn_count_a), 32'h0);
        checkOutput("rst_control_b", 32'(control_b), 32'h0);
        checkOutput("rst_spawn_count_b", 32'(spawn_count_b), 32'h0);

        applyStimulus(1'b0, 40'h0, 8'h00);
        enable_b = 1'b0; mheight_b = '0; mole_hit_b = '0;
        resetn = 1'b1;
        pulses = 0;
        repeat (8) begin
            stepCycle();
            if ((control_a | control_b) != 8'h00) pulses++;
        end
        checkOutput("disabled_no_pulse", 32'(pulses), 32'd0);

        // Periodic spawn, index and timeout against the reference model
        enable_a = 1'b1;
        exp_sc = 0;
        for (int e = 1; e <= 40; e++) begin
            stepCycle();
            exp_ctrl = 8'h00;
            if (e % 4 == 0) begin
                for (int i = 0; i < 8; i++) busy[i] = (cyc - 1) < release_at[i];
                start = lfsr_prev[2:0];
                found = 1'b0;
                pick  = 0;
                for (int n = 0; n < 8; n++) begin
                    pos = (int'(start) + n) % 8;
                    if (!found && !busy[pos]) begin
                        found = 1'b1;
                        pick  = pos;
                    end
                end
                if (found) begin
                    exp_ctrl = 8'b1 << pick;
                    release_at[pick] = cyc + 10;
                    exp_sc++;
                end
            end
            for (int i = 0; i < 8; i++) exp_active[i] = cyc < release_at[i];
            checkOutput("spawn_control", 32'(control_a), 32'(exp_ctrl));
            checkOutput("spawn_count", 32'(spawn_count_a), 32'(exp_sc));
            checkOutput("timeout_active", 32'(active_a), 32'(exp_active));
            checkOutput("active_count", 32'(active_count_a), 32'($countones(exp_active)));
        end

        // Rise then hit
        waitPulse(k, ok);
        mheight_a[39-5*k -: 5] = 5'd5;
        repeat (14) stepCycle();
        checkOutput("up_holds_past_timeout", 32'(active_a[k]), 32'd1);
        mole_hit_a[k] = 1'b1;
        stepCycle();
        checkOutput("hit_release", 32'(active_a[k]), 32'd0);
        mole_hit_a = 8'h00;
        pulses = 0;
        repeat (12) begin
            stepCycle();
            if (control_a[k]) pulses++;
        end
        checkOutput("no_relaunch_while_high", 32'(pulses), 32'd0);

        // Rise then sink back to height 0
        waitPulse(j, ok);
        checkOutput("other_mole_chosen", 32'(j != k), 32'd1);
        mheight_a[39-5*j -: 5] = 5'd5;
        repeat (3) stepCycle();
        checkOutput("rise_active", 32'(active_a[j]), 32'd1);
        mheight_a[39-5*j -: 5] = 5'd0;
        stepCycle();
        checkOutput("drop_release", 32'(active_a[j]), 32'd0);

        // Enable low drains trackers
        applyStimulus(1'b0, 40'h0, 8'h00);
        repeat (15) stepCycle();
        checkOutput("drain_active", 32'(active_a), 32'h0);
        checkOutput("drain_count", 32'(active_count_a), 32'h0);

        // No eligible mole: all heights raised
        applyStimulus(1'b1, {8{5'd3}}, 8'h00);
        sc_hold = spawn_count_a;
        pulses = 0;
        repeat (20) begin
            stepCycle();
            if (control_a != 8'h00) pulses++;
        end
        checkOutput("heights_block_pulse", 32'(pulses), 32'd0);
        checkOutput("heights_block_count", 32'(spawn_count_a), 32'(sc_hold));

        // No eligible mole: every hit line held high
        applyStimulus(1'b1, 40'h0, 8'hFF);
        pulses = 0;
        repeat (20) begin
            stepCycle();
            if (control_a != 8'h00) pulses++;
        end
        checkOutput("hits_block_pulse", 32'(pulses), 32'd0);
        checkOutput("hits_block_count", 32'(spawn_count_a), 32'(sc_hold));

        // Asynchronous reset cancels a pulse in flight
        applyStimulus(1'b1, 40'h0, 8'h00);
        waitPulse(k, ok);
        resetn = 1'b0;
        #1;
        checkOutput("async_control", 32'(control_a), 32'h0);
        checkOutput("async_spawn_count", 32'(spawn_count_a), 32'h0);
        checkOutput("async_active", 32'(active_a), 32'h0);
        applyStimulus(1'b0, 40'h0, 8'h00);
        repeat (3) stepCycle();
        resetn = 1'b1;

        // MAX_ACTIVE cap on the second instance
        enable_b = 1'b1;
        pulses = 0;
        repeat (40) begin
            stepCycle();
            if (control_b != 8'h00) pulses++;
        end
        checkOutput("cap_pulses", 32'(pulses), 32'd3);
        checkOutput("cap_active_count", 32'(active_count_b), 32'd3);
        checkOutput("cap_active_bits", 32'($countones(active_b)), 32'd3);
        checkOutput("cap_spawn_count", 32'(spawn_count_b), 32'd3);
        enable_b = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
